// File: rtl/jam_cost_server_if.sv
// Cost-table load channel between the table source and jam_cost_server.
interface jam_cost_server_if;
  logic       load_valid;
  logic [6:0] load_data;
  logic       load_ready;
  logic       load_done;

  modport master (output load_valid, load_data, input load_ready, load_done);
  modport slave  (input load_valid, load_data, output load_ready, load_done);
endinterface

// File: rtl/jam_cost_server.sv
// Serves an 8x8 cost table to an assignment engine and scores the engine's
// result against an expected minimum cost / match count, with a cycle timeout.
module jam_cost_server #(
  parameter logic [19:0] TIMEOUT = 20'hFFFFF
) (
  input  logic               CLK,
  input  logic               RST,
  jam_cost_server_if.slave   load_bus,
  input  logic [2:0]         W,
  input  logic [2:0]         J,
  output logic [6:0]         Cost,
  input  logic               Valid,
  input  logic [9:0]         MinCost,
  input  logic [3:0]         MatchCount,
  input  logic [9:0]         exp_mincost,
  input  logic [3:0]         exp_matchcount,
  output logic               res_valid,
  output logic [9:0]         res_mincost,
  output logic [3:0]         res_matchcount,
  output logic               pass,
  output logic               timeout,
  output logic [19:0]        cycles
);

  typedef enum logic [1:0] {LOAD, SERVE, DONE} state_t;

  state_t     state;
  logic [5:0] cnt;
  logic [6:0] cost_table [64];
  logic       accept;

  assign accept = (state == LOAD) && load_bus.load_valid;

  // Table storage survives reset; only an accepted load word overwrites it.
  always_ff @(posedge CLK) begin
    if (!RST && accept) begin
      cost_table[cnt] <= load_bus.load_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state               <= LOAD;
      cnt                 <= 6'd0;
      load_bus.load_ready <= 1'b1;
      load_bus.load_done  <= 1'b0;
      Cost                <= 7'd0;
      res_valid           <= 1'b0;
      res_mincost         <= 10'd0;
      res_matchcount      <= 4'd0;
      pass                <= 1'b0;
      timeout             <= 1'b0;
      cycles              <= 20'd0;
    end else begin
      case (state)
        LOAD: begin
          Cost <= 7'd0;
          if (load_bus.load_valid) begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'd63) begin
              state               <= SERVE;
              load_bus.load_ready <= 1'b0;
              load_bus.load_done  <= 1'b1;
            end
          end
        end
        // A result on the same edge as the timeout takes priority over the abort.
        SERVE: begin
          Cost <= cost_table[{W, J}];
          if (Valid) begin
            res_mincost    <= MinCost;
            res_matchcount <= MatchCount;
            res_valid      <= 1'b1;
            pass           <= (MinCost == exp_mincost) && (MatchCount == exp_matchcount);
            state          <= DONE;
          end else if (cycles == TIMEOUT) begin
            timeout   <= 1'b1;
            res_valid <= 1'b1;
            pass      <= 1'b0;
            state     <= DONE;
          end else if (cycles != 20'hFFFFF) begin
            cycles <= cycles + 20'd1;
          end
        end
        DONE: begin
          Cost <= cost_table[{W, J}];
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jam_cost_server.sv
// Scoreboard bench for jam_cost_server: table load, cost serving, result
// scoring, timeout and reset abort.
module tb_jam_cost_server;

  localparam logic [19:0] TO = 20'd20;

  typedef struct packed {
    logic [9:0] mc;
    logic [3:0] mcnt;
    logic       ps;
    logic       to;
  } res_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [2:0]  W = 3'd0;
  logic [2:0]  J = 3'd0;
  logic [6:0]  Cost;
  logic        Valid = 1'b0;
  logic [9:0]  MinCost = 10'd0;
  logic [3:0]  MatchCount = 4'd0;
  logic [9:0]  exp_mincost = 10'd0;
  logic [3:0]  exp_matchcount = 4'd0;
  logic        res_valid;
  logic [9:0]  res_mincost;
  logic [3:0]  res_matchcount;
  logic        pass;
  logic        timeout;
  logic [19:0] cycles;

  int checks = 0;
  int errors = 0;

  logic [6:0] model [64];
  int         model_cnt = 0;
  logic [6:0] cost_q [$];
  res_t       res_q [$];

  always #5 CLK = ~CLK;

  jam_cost_server_if load_bus ();

  jam_cost_server #(.TIMEOUT(TO)) dut (
    .CLK(CLK),
    .RST(RST),
    .load_bus(load_bus),
    .W(W),
    .J(J),
    .Cost(Cost),
    .Valid(Valid),
    .MinCost(MinCost),
    .MatchCount(MatchCount),
    .exp_mincost(exp_mincost),
    .exp_matchcount(exp_matchcount),
    .res_valid(res_valid),
    .res_mincost(res_mincost),
    .res_matchcount(res_matchcount),
    .pass(pass),
    .timeout(timeout),
    .cycles(cycles)
  );

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    load_bus.load_valid = 1'b0;
    load_bus.load_data = 7'd0;
    Valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    model_cnt = 0;
  endtask

  // Drives n words (optionally one idle cycle between words); the model learns each write.
  task automatic load_words(input int n, input int seed, input bit toggle);
    int sent = 0;
    bit phase = 1'b0;
    while (sent < n) begin
      @(negedge CLK);
      if (toggle) begin
        checks++;
        if ({load_bus.load_ready, load_bus.load_done} !== {model_cnt < 64, model_cnt >= 64})
          $display("[TB] FAIL toggle_ready_done after %0d accepts got %b%b want %b%b", model_cnt,
                   load_bus.load_ready, load_bus.load_done, model_cnt < 64, model_cnt >= 64);
        if ({load_bus.load_ready, load_bus.load_done} !== {model_cnt < 64, model_cnt >= 64})
          errors++;
      end
      if (toggle && phase) begin
        load_bus.load_valid = 1'b0;
      end else begin
        load_bus.load_valid = 1'b1;
        load_bus.load_data = 7'((model_cnt + seed) % 100);
        model[6'(model_cnt)] = load_bus.load_data;
        model_cnt++;
        sent++;
      end
      phase = !phase;
    end
    @(negedge CLK);
    load_bus.load_valid = 1'b0;
  endtask

  task automatic pulse_valid(input logic [9:0] mc, input logic [3:0] mcnt,
                             input logic [9:0] emc, input logic [3:0] ecnt, input bit captured);
    @(negedge CLK);
    Valid = 1'b1;
    MinCost = mc;
    MatchCount = mcnt;
    exp_mincost = emc;
    exp_matchcount = ecnt;
    if (captured) res_q.push_back(res_t'({mc, mcnt, (mc == emc) && (mcnt == ecnt), 1'b0}));
    @(negedge CLK);
    Valid = 1'b0;
  endtask

  task automatic wait_res(output bit ok);
    int n = 0;
    while (res_valid !== 1'b1 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    ok = (res_valid === 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({load_bus.load_ready, load_bus.load_done} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL reset_handshake got %b%b want 10", load_bus.load_ready, load_bus.load_done);
    end
    checks++;
    if ({Cost, res_valid, res_mincost, res_matchcount, pass, timeout, cycles} !== 44'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got cost=%0d rv=%b mc=%0d cnt=%0d pass=%b to=%b cyc=%0d want all 0",
               Cost, res_valid, res_mincost, res_matchcount, pass, timeout, cycles);
    end
  endtask

  task automatic test_load_cost();
    logic [2:0] ws [6] = '{3'd3, 3'd5, 3'd0, 3'd7, 3'd1, 3'd2};
    logic [2:0] js [6] = '{3'd5, 3'd3, 3'd0, 3'd7, 3'd6, 3'd4};
    logic [6:0] exp;
    do_reset();
    load_words(64, 0, 1'b0);
    checks++;
    if ({load_bus.load_ready, load_bus.load_done} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL load_done_after_64 got %b%b want 01", load_bus.load_ready, load_bus.load_done);
    end
    // Junk load words while serving must not disturb the table.
    load_bus.load_valid = 1'b1;
    load_bus.load_data = 7'h7F;
    for (int k = 0; k <= 6; k++) begin
      @(negedge CLK);
      if (k > 0) begin
        exp = cost_q.pop_front();
        checks++;
        if (Cost !== exp) begin
          errors++;
          $display("[TB] FAIL cost_w%0d_j%0d got %0d want %0d", ws[k-1], js[k-1], Cost, exp);
        end
      end
      if (k < 6) begin
        W = ws[k];
        J = js[k];
        cost_q.push_back(model[{ws[k], js[k]}]);
      end
    end
    load_bus.load_valid = 1'b0;
  endtask

  task automatic test_pass();
    bit ok;
    res_t exp;
    do_reset();
    load_words(64, 0, 1'b0);
    pulse_valid(10'd300, 4'd2, 10'd300, 4'd2, 1'b1);
    wait_res(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL pass_res_valid got %b want 1", res_valid);
    end else begin
      exp = res_q.pop_front();
      checks++;
      if (res_t'({res_mincost, res_matchcount, pass, timeout}) !== exp) begin
        errors++;
        $display("[TB] FAIL pass_result got mc=%0d cnt=%0d pass=%b to=%b want mc=%0d cnt=%0d pass=%b to=%b",
                 res_mincost, res_matchcount, pass, timeout, exp.mc, exp.mcnt, exp.ps, exp.to);
      end
    end
  endtask

  task automatic test_fail_hold();
    bit ok;
    res_t exp;
    do_reset();
    load_words(64, 0, 1'b0);
    pulse_valid(10'd300, 4'd2, 10'd300, 4'd3, 1'b1);
    wait_res(ok);
    exp = res_q.pop_front();
    checks++;
    if (!ok || res_t'({res_mincost, res_matchcount, pass, timeout}) !== exp) begin
      errors++;
      $display("[TB] FAIL mismatch_result got rv=%b mc=%0d cnt=%0d pass=%b to=%b want rv=1 mc=%0d cnt=%0d pass=%b to=%b",
               res_valid, res_mincost, res_matchcount, pass, timeout, exp.mc, exp.mcnt, exp.ps, exp.to);
    end
    repeat (3) @(negedge CLK);
    pulse_valid(10'd123, 4'd7, 10'd123, 4'd7, 1'b0);
    repeat (2) @(negedge CLK);
    checks++;
    if ({res_valid, res_t'({res_mincost, res_matchcount, pass, timeout})} !== {1'b1, exp}) begin
      errors++;
      $display("[TB] FAIL done_hold got rv=%b mc=%0d cnt=%0d pass=%b want rv=1 mc=%0d cnt=%0d pass=%b",
               res_valid, res_mincost, res_matchcount, pass, exp.mc, exp.mcnt, exp.ps);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    res_t exp;
    do_reset();
    load_words(64, 0, 1'b0);
    res_q.push_back(res_t'({10'd0, 4'd0, 1'b0, 1'b1}));
    wait_res(ok);
    exp = res_q.pop_front();
    checks++;
    if (!ok || res_t'({res_mincost, res_matchcount, pass, timeout}) !== exp) begin
      errors++;
      $display("[TB] FAIL timeout_result got rv=%b mc=%0d cnt=%0d pass=%b to=%b want rv=1 mc=0 cnt=0 pass=0 to=1",
               res_valid, res_mincost, res_matchcount, pass, timeout);
    end
    checks++;
    if (cycles !== TO) begin
      errors++;
      $display("[TB] FAIL timeout_cycles got %0d want %0d", cycles, TO);
    end
    repeat (8) @(negedge CLK);
    pulse_valid(10'd5, 4'd5, 10'd5, 4'd5, 1'b0);
    repeat (2) @(negedge CLK);
    checks++;
    if ({cycles, res_valid, pass, timeout, res_mincost} !== {TO, 1'b1, 1'b0, 1'b1, 10'd0}) begin
      errors++;
      $display("[TB] FAIL timeout_hold got cyc=%0d rv=%b pass=%b to=%b mc=%0d want cyc=%0d rv=1 pass=0 to=1 mc=0",
               cycles, res_valid, pass, timeout, res_mincost, TO);
    end
  endtask

  task automatic test_valid_wins();
    int n = 0;
    res_t exp;
    do_reset();
    load_words(64, 0, 1'b0);
    while (cycles !== TO && n < 60) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (cycles !== TO || res_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reach_timeout_edge got cyc=%0d rv=%b want cyc=%0d rv=0", cycles, res_valid, TO);
    end
    Valid = 1'b1;
    MinCost = 10'd77;
    MatchCount = 4'd4;
    exp_mincost = 10'd77;
    exp_matchcount = 4'd4;
    res_q.push_back(res_t'({10'd77, 4'd4, 1'b1, 1'b0}));
    @(negedge CLK);
    Valid = 1'b0;
    exp = res_q.pop_front();
    checks++;
    if ({res_valid, res_t'({res_mincost, res_matchcount, pass, timeout})} !== {1'b1, exp}) begin
      errors++;
      $display("[TB] FAIL valid_wins got rv=%b mc=%0d cnt=%0d pass=%b to=%b want rv=1 mc=77 cnt=4 pass=1 to=0",
               res_valid, res_mincost, res_matchcount, pass, timeout);
    end
  endtask

  task automatic test_toggle_load();
    logic [6:0] exp;
    do_reset();
    load_words(64, 17, 1'b1);
    checks++;
    if ({load_bus.load_ready, load_bus.load_done} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL toggle_done_on_64th got %b%b want 01", load_bus.load_ready, load_bus.load_done);
    end
    W = 3'd6;
    J = 3'd2;
    cost_q.push_back(model[{3'd6, 3'd2}]);
    @(negedge CLK);
    exp = cost_q.pop_front();
    checks++;
    if (Cost !== exp) begin
      errors++;
      $display("[TB] FAIL toggle_cost_w6_j2 got %0d want %0d", Cost, exp);
    end
  endtask

  task automatic test_reset_midload();
    logic [6:0] exp;
    do_reset();
    load_words(30, 0, 1'b0);
    pulse_valid(10'd9, 4'd1, 10'd9, 4'd1, 1'b0);
    checks++;
    if ({res_valid, Cost, load_bus.load_ready} !== {1'b0, 7'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL valid_in_load got rv=%b cost=%0d ready=%b want rv=0 cost=0 ready=1",
               res_valid, Cost, load_bus.load_ready);
    end
    do_reset();
    checks++;
    if ({load_bus.load_ready, load_bus.load_done} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL midload_reset got %b%b want 10", load_bus.load_ready, load_bus.load_done);
    end
    load_words(63, 50, 1'b0);
    checks++;
    if ({load_bus.load_ready, load_bus.load_done} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL reload_63_words got %b%b want 10", load_bus.load_ready, load_bus.load_done);
    end
    load_words(1, 50, 1'b0);
    checks++;
    if ({load_bus.load_ready, load_bus.load_done} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL reload_64th_word got %b%b want 01", load_bus.load_ready, load_bus.load_done);
    end
    W = 3'd0;
    J = 3'd0;
    cost_q.push_back(model[6'd0]);
    @(negedge CLK);
    exp = cost_q.pop_front();
    checks++;
    if (Cost !== exp) begin
      errors++;
      $display("[TB] FAIL reload_cost_w0_j0 got %0d want %0d", Cost, exp);
    end
  endtask

  initial begin
    load_bus.load_valid = 1'b0;
    load_bus.load_data = 7'd0;
    test_reset();
    test_load_cost();
    test_pass();
    test_fail_hold();
    test_timeout();
    test_valid_wins();
    test_toggle_load();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
